// File: rtl/picomips_pkg.sv
// picomips_pkg: shared constants and types for the picoMIPS register file and I/O buffer.
//   N_DEF / ABITS_DEF : default data width and register address width
//   R0, IN_A_DEF, OUT_A_DEF : hard-wired zero register and default I/O-mapped addresses
//   FLAG_V/N/Z/C : bit positions of the ALU flags in the 4-bit flags word
//   in_state_t : input-buffer FSM states
package picomips_pkg;

  localparam int N_DEF     = 8;
  localparam int ABITS_DEF = 3;

  localparam int R0        = 0;
  localparam int IN_A_DEF  = 6;
  localparam int OUT_A_DEF = 7;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } in_state_t;

endpackage

// File: rtl/pico_io_buf.sv
// pico_io_buf: input-port buffer FSM, output-port buffer and core stall generation.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   in_pop               current instruction consumes the input buffer
//   in_data, in_valid    external input word and its valid strobe
//   in_ready             buffer empty, able to capture
//   in_buf               captured input word
//   wr_en, wr_addr       register write request from the decoder
//   wr_data              write data (used when wr_addr hits OUT_A)
//   out_ack              external consumer takes the output buffer
//   out_data, out_valid  output buffer contents and full flag
//   stall                core must hold PC, instruction suppressed
module pico_io_buf
  import picomips_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ABITS = ABITS_DEF,
  parameter int OUT_A = OUT_A_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_pop,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     in_buf,
  input  logic             wr_en,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             out_ack,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  output logic             stall
);

  in_state_t state, state_nxt;
  logic      wr_out_req;
  logic      wr_out;
  logic      capture;

  assign wr_out_req = wr_en && (wr_addr == ABITS'(OUT_A));
  assign wr_out     = wr_out_req && !stall;
  // Capture is independent of stall so a stalled pop can be released by arriving input.
  assign capture    = (state == EMPTY) && in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_valid) state_nxt = FULL;
      // Data offered during a pop is not taken; in_ready was low this cycle.
      FULL:    if (in_pop && !stall) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    in_ready = (state == EMPTY);
    stall    = (in_pop && (state == EMPTY)) ||
               (wr_out_req && out_valid && !out_ack);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        in_buf <= '0;
    else if (capture) in_buf <= in_data;
  end

  // A same-cycle write wins over an acknowledge: new word replaces the taken one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (wr_out) begin
      out_data  <= wr_data;
      out_valid <= 1'b1;
    end else if (out_ack && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pico_regfile_io.sv
// pico_regfile_io: picoMIPS register file with memory-mapped input/output buffers.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   ra_addr/ra_data     read port A (combinational) -> ALU operand a
//   rb_addr/rb_data     read port B (combinational) -> ALU operand b
//   wr_en/wr_addr/wr_data  write-back of ALU result
//   flags_we/flags_in   ALU flags {V,N,Z,C} latch request
//   flags               registered flags to branch logic
//   in_pop, in_data, in_valid, in_ready  buffered input port
//   out_data, out_valid, out_ack         buffered output port
//   stall               core must hold PC; instruction suppressed
module pico_regfile_io
  import picomips_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ABITS = ABITS_DEF,
  parameter int IN_A  = IN_A_DEF,
  parameter int OUT_A = OUT_A_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ABITS-1:0] ra_addr,
  input  logic [ABITS-1:0] rb_addr,
  output logic [N-1:0]     ra_data,
  output logic [N-1:0]     rb_data,
  input  logic             wr_en,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic             flags_we,
  input  logic [3:0]       flags_in,
  output logic [3:0]       flags,
  input  logic             in_pop,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             stall
);

  localparam int NREGS = 2 ** ABITS;

  logic [N-1:0] regs [NREGS];
  logic [N-1:0] in_buf;
  logic         reg_we;

  pico_io_buf #(
    .N     (N),
    .ABITS (ABITS),
    .OUT_A (OUT_A)
  ) u_io_buf (
    .clk       (clk),
    .reset     (reset),
    .in_pop    (in_pop),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_buf    (in_buf),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .stall     (stall)
  );

  // R0 and the input address are read-only; the output address is handled by the buffer.
  assign reg_we = wr_en && !stall &&
                  (wr_addr != ABITS'(R0)) &&
                  (wr_addr != ABITS'(IN_A)) &&
                  (wr_addr != ABITS'(OUT_A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  flags <= 4'b0000;
    else if (flags_we && !stall) flags <= flags_in;
  end

  // No write bypass: a read in the same cycle as a write sees the old value.
  always_comb begin
    if (ra_addr == ABITS'(R0))         ra_data = '0;
    else if (ra_addr == ABITS'(IN_A))  ra_data = in_buf;
    else if (ra_addr == ABITS'(OUT_A)) ra_data = out_data;
    else                               ra_data = regs[ra_addr];
  end

  always_comb begin
    if (rb_addr == ABITS'(R0))         rb_data = '0;
    else if (rb_addr == ABITS'(IN_A))  rb_data = in_buf;
    else if (rb_addr == ABITS'(OUT_A)) rb_data = out_data;
    else                               rb_data = regs[rb_addr];
  end

endmodule

// File: tb/tb_pico_regfile_io.sv
// tb_pico_regfile_io: directed self-checking bench for pico_regfile_io.
module tb_pico_regfile_io;
  import picomips_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] ra_addr, rb_addr;
  logic [7:0] ra_data, rb_data;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       flags_we;
  logic [3:0] flags_in, flags;
  logic       in_pop;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ack, stall;

  int n_checks = 0;
  int n_fail   = 0;

  pico_regfile_io dut (
    .clk       (clk),
    .reset     (reset),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .ra_data   (ra_data),
    .rb_data   (rb_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_we  (flags_we),
    .flags_in  (flags_in),
    .flags     (flags),
    .in_pop    (in_pop),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ra_addr = 3'd0; rb_addr = 3'd0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    flags_we = 1'b0; flags_in = 4'b0000;
    in_pop = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    out_ack = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Register write latency and no-bypass read
    ra_addr = 3'd3; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;
    settle();
    check("r3_old", 32'(ra_data), 32'h00);
    tick();
    wr_en = 1'b0;
    settle();
    check("r3_new", 32'(ra_data), 32'h5A);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; ra_addr = 3'd0;
    tick();
    wr_en = 1'b0;
    settle();
    check("r0_zero", 32'(ra_data), 32'h00);

    // Flags latch and hold
    flags_we = 1'b1; flags_in = 4'b1010;
    tick();
    flags_we = 1'b0; flags_in = 4'b0101;
    settle();
    check("flags_latch", 32'(flags), 32'hA);
    check("flag_v", 32'(flags[FLAG_V]), 32'd1);
    tick();
    check("flags_hold", 32'(flags), 32'hA);

    // Input capture and pop
    in_data = 8'h21; in_valid = 1'b1;
    settle();
    check("in_ready_empty", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; ra_addr = 3'd6;
    settle();
    check("in_ready_full", 32'(in_ready), 32'd0);
    check("in_buf_read", 32'(ra_data), 32'h21);
    in_pop = 1'b1;
    settle();
    check("pop_no_stall", 32'(stall), 32'd0);
    tick();
    in_pop = 1'b0;
    settle();
    check("pop_empties", 32'(in_ready), 32'd1);

    // Pop on empty buffer stalls writes and flags until input arrives
    in_pop = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h33;
    flags_we = 1'b1; flags_in = 4'b1111; rb_addr = 3'd2;
    settle();
    check("stall_empty_pop", 32'(stall), 32'd1);
    tick();
    check("r2_suppressed", 32'(rb_data), 32'h00);
    check("flags_suppressed", 32'(flags), 32'hA);
    in_valid = 1'b1; in_data = 8'h44;
    settle();
    check("stall_while_capture", 32'(stall), 32'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("stall_cleared", 32'(stall), 32'd0);
    check("in_buf_44", 32'(ra_data), 32'h44);
    tick();
    in_pop = 1'b0; wr_en = 1'b0; flags_we = 1'b0;
    settle();
    check("r2_written", 32'(rb_data), 32'h33);
    check("flags_written", 32'(flags), 32'hF);
    check("popped_empty", 32'(in_ready), 32'd1);

    // Output buffer: full write stalls, ack lets a new word through
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h7F; ra_addr = 3'd7;
    tick();
    wr_data = 8'h10; out_ack = 1'b0;
    settle();
    check("out_valid_set", 32'(out_valid), 32'd1);
    check("out_read_7f", 32'(ra_data), 32'h7F);
    check("out_full_stall", 32'(stall), 32'd1);
    tick();
    check("out_hold_7f", 32'(out_data), 32'h7F);
    out_ack = 1'b1;
    settle();
    check("ack_unstalls", 32'(stall), 32'd0);
    tick();
    wr_en = 1'b0; out_ack = 1'b0;
    settle();
    check("out_new_10", 32'(out_data), 32'h10);
    check("out_valid_stays", 32'(out_valid), 32'd1);
    out_ack = 1'b1;
    tick();
    check("ack_clears", 32'(out_valid), 32'd0);
    tick();
    out_ack = 1'b0;
    settle();
    check("ack_idle_ignored", 32'(out_valid), 32'd0);
    check("ack_idle_data", 32'(out_data), 32'h10);

    // Pop and in_valid together while FULL: no capture until next cycle
    ra_addr = 3'd6;
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_pop = 1'b1; in_data = 8'h66;
    tick();
    in_pop = 1'b0;
    settle();
    check("pop_valid_empty", 32'(in_ready), 32'd1);
    check("pop_valid_keep55", 32'(ra_data), 32'h55);
    tick();
    in_valid = 1'b0;
    settle();
    check("capture_next_66", 32'(ra_data), 32'h66);
    check("capture_next_full", 32'(in_ready), 32'd0);

    // Asynchronous reset mid-run with both buffers full
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    settle();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    ra_addr = 3'd3; rb_addr = 3'd6;
    #1;
    reset = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'h00);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_flags", 32'(flags), 32'h0);
    check("async_r3", 32'(ra_data), 32'h00);
    check("async_in_buf", 32'(rb_data), 32'h00);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
